// File: rtl/led_pkg.sv
// +----------------------------------------------------------------------------+
// | led_pkg : shared types and defaults for the LED blink sequencer             |
// | Rev 1.0  initial release                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } led_state_t;

  localparam int RATIO_DEF  = 100;
  localparam int TICK_W_DEF = 8;
  localparam int REP_W_DEF  = 8;

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// +----------------------------------------------------------------------------+
// | led_tick_gen : divides the system clock into a one-cycle tick every RATIO   |
// | clocks; clear restarts the phase so the first tick lands RATIO clocks later |
// | Rev 1.0  initial release                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module led_tick_gen
  import led_pkg::*;
#(
  parameter int RATIO = RATIO_DEF
) (
  input  logic pin_clock,
  input  logic pin_n_reset,
  input  logic clear,
  output logic tick
);

  localparam int                 c_CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(RATIO - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_last;

  assign w_last = (r_cnt == c_LAST);
  // Tick is suppressed while clear is held so a restart never sees a stale pulse.
  assign tick   = w_last && !clear;

  always_ff @(posedge pin_clock or negedge pin_n_reset) begin
    if (!pin_n_reset) begin
      r_cnt <= '0;
    end else if (clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_blink_sequencer.sv
// +----------------------------------------------------------------------------+
// | led_blink_sequencer : runs one LED through repeat_cnt on/off cycles with    |
// | durations in divided ticks; start/abort handshake with busy/done status.    |
// | Option macro LED_ACTIVE_LOW_EN : invert led polarity (idle/reset drive 1).  |
// | Rev 1.0  initial release                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module led_blink_sequencer
  import led_pkg::*;
#(
  parameter int RATIO  = RATIO_DEF,
  parameter int TICK_W = TICK_W_DEF,
  parameter int REP_W  = REP_W_DEF
) (
  input  logic              pin_clock,
  input  logic              pin_n_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [TICK_W-1:0] on_ticks,
  input  logic [TICK_W-1:0] off_ticks,
  input  logic [REP_W-1:0]  repeat_cnt,
  output logic              busy,
  output logic              done,
  output logic              led
);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic c_LED_ON  = 1'b0;
  localparam logic c_LED_OFF = 1'b1;
`else
  localparam logic c_LED_ON  = 1'b1;
  localparam logic c_LED_OFF = 1'b0;
`endif

  led_state_t        r_state;
  logic [TICK_W-1:0] r_on_ticks;
  logic [TICK_W-1:0] r_off_ticks;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [REP_W-1:0]  r_rep;
  logic [REP_W-1:0]  r_cyc_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_led;

  logic              w_tick;
  logic              w_clear;
  logic [TICK_W-1:0] w_on_eff;
  logic [TICK_W-1:0] w_off_eff;
  logic              w_on_last;
  logic              w_off_last;
  logic [REP_W-1:0]  w_cyc_next;
  logic              w_seq_end;

  // Divider is held at zero in IDLE, so the ON phase starts on a fresh tick period.
  assign w_clear = (r_state == IDLE);

  led_tick_gen #(
    .RATIO (RATIO)
  ) u_tick_gen (
    .pin_clock   (pin_clock),
    .pin_n_reset (pin_n_reset),
    .clear       (w_clear),
    .tick        (w_tick)
  );

  assign w_on_eff   = (on_ticks  == '0) ? TICK_W'(1) : on_ticks;
  assign w_off_eff  = (off_ticks == '0) ? TICK_W'(1) : off_ticks;
  assign w_on_last  = (r_tick_cnt == r_on_ticks  - 1'b1);
  assign w_off_last = (r_tick_cnt == r_off_ticks - 1'b1);
  assign w_cyc_next = r_cyc_cnt + 1'b1;
  // A zero repeat count never matches, so the cycle counter simply wraps.
  assign w_seq_end  = (r_rep != '0) && (w_cyc_next == r_rep);

  always_ff @(posedge pin_clock or negedge pin_n_reset) begin
    if (!pin_n_reset) begin
      r_state     <= IDLE;
      r_on_ticks  <= '0;
      r_off_ticks <= '0;
      r_tick_cnt  <= '0;
      r_rep       <= '0;
      r_cyc_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_led       <= c_LED_OFF;
    end else begin
      r_done <= 1'b0;
      if ((r_state != IDLE) && abort) begin
        r_state    <= IDLE;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_led      <= c_LED_OFF;
        r_tick_cnt <= '0;
        r_cyc_cnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !abort) begin
              r_on_ticks  <= w_on_eff;
              r_off_ticks <= w_off_eff;
              r_rep       <= repeat_cnt;
              r_tick_cnt  <= '0;
              r_cyc_cnt   <= '0;
              r_state     <= ON;
              r_busy      <= 1'b1;
              r_led       <= c_LED_ON;
            end
          end
          ON: begin
            if (w_tick) begin
              if (w_on_last) begin
                r_tick_cnt <= '0;
                r_state    <= OFF;
                r_led      <= c_LED_OFF;
              end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
              end
            end
          end
          OFF: begin
            if (w_tick) begin
              if (w_off_last) begin
                r_tick_cnt <= '0;
                if (w_seq_end) begin
                  r_state   <= IDLE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_cyc_cnt <= '0;
                end else begin
                  r_state   <= ON;
                  r_led     <= c_LED_ON;
                  r_cyc_cnt <= w_cyc_next;
                end
              end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_led   <= c_LED_OFF;
          end
        endcase
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign led  = r_led;

endmodule

`default_nettype wire

// File: tb/tb_led_blink_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_led_blink_sequencer : self-checking bench for led_blink_sequencer, RATIO=4|
// | Rev 1.0  initial release                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_led_blink_sequencer;

  localparam int R = 4;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic LOFF = 1'b1;
`else
  localparam logic LOFF = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] on_t  = 8'd0;
  logic [7:0] off_t = 8'd0;
  logic [7:0] rep_t = 8'd0;
  logic       busy;
  logic       done;
  logic       led;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  led_blink_sequencer #(
    .RATIO  (R),
    .TICK_W (8),
    .REP_W  (8)
  ) dut (
    .pin_clock   (clk),
    .pin_n_reset (rst_n),
    .start       (start),
    .abort       (abort),
    .on_ticks    (on_t),
    .off_ticks   (off_t),
    .repeat_cnt  (rep_t),
    .busy        (busy),
    .done        (done),
    .led         (led)
  );

  // Expected {busy,done,led} in cycle k after the start edge (k=1 is the first ON cycle).
  function automatic logic [2:0] model(int k, int on, int off, int rp);
    int on_e;
    int off_e;
    int per;
    on_e  = (on  == 0) ? 1 : on;
    off_e = (off == 0) ? 1 : off;
    per   = (on_e + off_e) * R;
    if (k <= 0) return {1'b0, 1'b0, LOFF};
    if (rp != 0 && k > rp * per) begin
      if (k == rp * per + 1) return {1'b0, 1'b1, LOFF};
      return {1'b0, 1'b0, LOFF};
    end
    return {1'b1, 1'b0, (((k - 1) % per) < on_e * R) ? ~LOFF : LOFF};
  endfunction

  function automatic int seq_len(int on, int off, int rp);
    return (((on == 0) ? 1 : on) + ((off == 0) ? 1 : off)) * R * rp;
  endfunction

  task automatic launch(int on, int off, int rp);
    @(negedge clk);
    on_t  = 8'(on);
    off_t = 8'(off);
    rep_t = 8'(rp);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    e = {1'b0, 1'b0, LOFF};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, led} !== e) $display("FAIL reset i=%0d: got %b expected %b", i, {busy, done, led}, e);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, led} !== e) $display("FAIL reset_release i=%0d: got %b expected %b", i, {busy, done, led}, e);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic [2:0] e;
    launch(2, 3, 2);
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      e = model(k, 2, 3, 2);
      n_checks++;
      if ({busy, done, led} !== e) $display("FAIL basic k=%0d: got %b expected %b", k, {busy, done, led}, e);
      else n_pass++;
    end
  endtask

  task automatic test_zero();
    logic [2:0] e;
    launch(0, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      e = model(k, 0, 0, 1);
      n_checks++;
      if ({busy, done, led} !== e) $display("FAIL zero k=%0d: got %b expected %b", k, {busy, done, led}, e);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [2:0] e;
    int on;
    int off;
    int rp;
    int n;
    for (int it = 0; it < 6; it++) begin
      on  = int'($urandom_range(0, 5));
      off = int'($urandom_range(0, 5));
      rp  = int'($urandom_range(1, 3));
      n   = seq_len(on, off, rp) + 3;
      launch(on, off, rp);
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        e = model(k, on, off, rp);
        n_checks++;
        if ({busy, done, led} !== e)
          $display("FAIL random on=%0d off=%0d rep=%0d k=%0d: got %b expected %b", on, off, rp, k, {busy, done, led}, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_forever_abort();
    logic [2:0] e;
    launch(1, 1, 0);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      e = model(k, 1, 1, 0);
      n_checks++;
      if ({busy, done, led} !== e) $display("FAIL forever k=%0d: got %b expected %b", k, {busy, done, led}, e);
      else n_pass++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, done, led} !== {1'b0, 1'b1, LOFF})
      $display("FAIL abort_busy: got %b expected %b", {busy, done, led}, {1'b0, 1'b1, LOFF});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, done, led} !== {1'b0, 1'b0, LOFF})
      $display("FAIL abort_after: got %b expected %b", {busy, done, led}, {1'b0, 1'b0, LOFF});
    else n_pass++;
  endtask

  task automatic test_ignore_busy();
    logic [2:0] e;
    launch(2, 1, 1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      e = model(k, 2, 1, 1);
      n_checks++;
      if ({busy, done, led} !== e) $display("FAIL ignore_busy k=%0d: got %b expected %b", k, {busy, done, led}, e);
      else n_pass++;
      if (k == 3) begin
        on_t  = 8'd4;
        off_t = 8'd4;
        rep_t = 8'd3;
        start = 1'b1;
      end
      if (k == 4) start = 1'b0;
    end
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, led} !== {1'b0, 1'b0, LOFF})
        $display("FAIL abort_start_idle i=%0d: got %b expected %b", i, {busy, done, led}, {1'b0, 1'b0, LOFF});
      else n_pass++;
    end
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, led} !== {1'b0, 1'b0, LOFF})
      $display("FAIL abort_start_release: got %b expected %b", {busy, done, led}, {1'b0, 1'b0, LOFF});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    @(negedge clk);
    on_t  = 8'd1;
    off_t = 8'd1;
    rep_t = 8'd1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = (k <= 9) ? model(k, 1, 1, 1) : model(k - 9, 1, 1, 1);
      n_checks++;
      if ({busy, done, led} !== e) $display("FAIL back_to_back k=%0d: got %b expected %b", k, {busy, done, led}, e);
      else n_pass++;
      if (k == 17) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    launch(3, 1, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e = model(k, 3, 1, 1);
      n_checks++;
      if ({busy, done, led} !== e) $display("FAIL reset_mid_pre k=%0d: got %b expected %b", k, {busy, done, led}, e);
      else n_pass++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, led} !== {1'b0, 1'b0, LOFF})
      $display("FAIL reset_mid_async: got %b expected %b", {busy, done, led}, {1'b0, 1'b0, LOFF});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, led} !== {1'b0, 1'b0, LOFF})
        $display("FAIL reset_mid_hold i=%0d: got %b expected %b", i, {busy, done, led}, {1'b0, 1'b0, LOFF});
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, led} !== {1'b0, 1'b0, LOFF})
        $display("FAIL reset_mid_release i=%0d: got %b expected %b", i, {busy, done, led}, {1'b0, 1'b0, LOFF});
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_random();
    test_forever_abort();
    test_ignore_busy();
    test_abort_start_idle();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
